winograd_tile_stitcher: RTL
===========================

// Module: winograd_tile_stitcher
// PURPOSE
//  Sequential, parametrised tile-to-image assembler for the Winograd output path.
//  - Accepts TILE x TILE output tiles, one per handshake, in raster tile order.
//  - Stores them into an IMG_ROWS x IMG_COLS register image.
//  - Clips tile elements that overhang the right or bottom edge.
//  - Once the frame is complete, streams the image row-major, one element per cycle.
//  - Sits between the Winograd output transform and the result writeback.
// PARAMETERS
//  DATA_WIDTH  32  element width in bits
//  TILE        4   tile edge length in elements
//  IMG_ROWS    8   image height in elements
//  IMG_COLS    10  image width in elements
//  Derived: TILES_R=ceil(IMG_ROWS/TILE), TILES_C=ceil(IMG_COLS/TILE), N_TILES=TILES_R*TILES_C
// PORTS
//  clk         in   1                    single clock, rising edge
//  rst_n       in   1                    synchronous, active-low reset
//  abort       in   1                    synchronous frame abort
//  tile_valid  in   1                    input tile valid
//  tile_ready  out  1                    input tile ready
//  tile_data   in   DATA_WIDTH*TILE*TILE flattened tile; element (i,j) at index i*TILE+j, LSB first
//  pix_valid   out  1                    output element valid
//  pix_ready   in   1                    output element ready
//  pix_data    out  DATA_WIDTH           output element
//  pix_row     out  $clog2(IMG_ROWS)     row of pix_data
//  pix_col     out  $clog2(IMG_COLS)     column of pix_data
//  pix_last    out  1                    high on the final element (IMG_ROWS-1, IMG_COLS-1)
//  busy        out  1                    high whenever state != COLLECT or tile_idx != 0
//  frame_done  out  1                    one-cycle pulse, the cycle after the pix_last handshake
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//  - state=COLLECT; tile counters (tr,tc)=0; pixel counters (r,c)=0.
//  - Outputs: tile_ready=0 while rst_n=0, then 1 from the first cycle after release;
//    pix_valid=0, pix_last=0, frame_done=0, busy=0.
//  - Image buffer is NOT reset. Every in-bounds cell is overwritten each frame.
//  States: COLLECT -> DRAIN -> COLLECT.
//  COLLECT:
//  - tile_ready=1, pix_valid=0.
//  - On tile_valid&&tile_ready, write element (i,j) to img[tr*TILE+i][tc*TILE+j]
//    only if the row is < IMG_ROWS and the column is < IMG_COLS. Other elements are dropped.
//  - Then advance tc. On wrap (tc==TILES_C-1), tc=0 and tr++.
//  - The handshake on tile N_TILES-1 moves to DRAIN, with pix_valid=1 next cycle.
//  DRAIN:
//  - tile_ready=0.
//  - pix_valid=1; pix_data = img[r][c] (combinational read); pix_row=r, pix_col=c.
//  - Outputs are held stable while pix_ready=0.
//  - On handshake, c++. On wrap, c=0 and r++.
//  - The pix_last handshake returns to COLLECT with all counters 0. frame_done pulses the next cycle.
//  - A new frame is accepted from that same next cycle, giving zero bubble beyond one cycle.
//  Throughput: 1 tile/cycle in, 1 element/cycle out.
//  Frame latency: N_TILES + IMG_ROWS*IMG_COLS cycles with no back-pressure.
//  abort=1 at an edge, in any state:
//  - state=COLLECT, all counters 0, pix_valid=0, no frame_done pulse.
//  - Any tile or pixel handshake in the same cycle is discarded.
//  - rst_n has priority over abort.
//  Simultaneous tile_valid while in DRAIN: ignored (tile_ready=0). The upstream holds the tile.
//  Elaboration asserts: TILE>=2, IMG_ROWS>=1, IMG_COLS>=1.
// STRUCTURE
//  Package winograd_pkg:
//  - stitch_state_e enum {COLLECT, DRAIN}.
//  - Function ceil_div(a,b) for TILES_R and TILES_C.
//  - Localparam element-index helper.
//  Sub-module winograd_raster_counter #(ROWS,COLS):
//  - Ports: clk, rst_n, clr, inc, row, col, last.
//  - Instantiated twice: tile grid (TILES_R x TILES_C) and pixel grid (IMG_ROWS x IMG_COLS).
//  - Image buffer and write-clip decode live in the top module.
// TESTING  (defaults unless stated; tile k element (i,j) = k*16+i*4+j, k=0..5)
//  1 Feed 6 tiles, pix_ready=1 -> 80 outputs row-major with:
//    (0,0)=0, (0,9)=33, (4,0)=48, (7,9)=93; pix_last only on (7,9);
//    tile-2/5 columns 2,3 never appear; frame_done pulses once.
//  2 Same frame, pix_ready toggling 1,0,1,0 -> pix_data/row/col stable while stalled;
//    same 80 values in order; 160 cycles to drain.
//  3 Accept 3 tiles, assert abort 1 cycle, then feed a fresh 6-tile frame with k+100 offsets
//    -> output (0,0)=1600, no stale values, busy=0 the cycle after abort.
//  4 rst_n=0 for 1 cycle at drain element 20 -> pix_valid=0 next cycle, tile_ready=1 after release;
//    a following full frame streams correctly.
//  5 Back-to-back frames, tile_valid held high through DRAIN -> no tile accepted during DRAIN;
//    second frame accepted starting the cycle after pix_last.
//  6 IMG_ROWS=5, IMG_COLS=5, TILE=2 -> 9 tiles accepted, 25 outputs;
//    (4,4) = tile 8 element (0,0); row/col 5 never produced.

Source files
------------

// File: rtl/winograd_pkg.sv
// Shared types and elaboration helpers for the Winograd output-path tile stitcher.
package winograd_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } stitch_state_e;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  // Counter width that stays legal for a single-entry dimension.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit offset of tile element (i,j) within the flattened, LSB-first tile bus.
  function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned j,
                                           input int unsigned tile, input int unsigned dw);
    return (i * tile + j) * dw;
  endfunction

endpackage

// File: rtl/winograd_raster_counter.sv
// Row-major ROWS x COLS position counter; wraps to (0,0) after the last position.
module winograd_raster_counter
  import winograd_pkg::*;
#(
  parameter int unsigned ROWS = 2,
  parameter int unsigned COLS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       inc,
  output logic [cnt_width(ROWS)-1:0] row,
  output logic [cnt_width(COLS)-1:0] col,
  output logic                       last
);

  localparam int unsigned RW = cnt_width(ROWS);
  localparam int unsigned CW = cnt_width(COLS);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (row == ROW_MAX) && (col == COL_MAX);

endmodule

// File: rtl/winograd_tile_stitcher.sv
// Assembles raster-ordered TILE x TILE tiles into an image buffer, then streams it row-major.
module winograd_tile_stitcher
  import winograd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TILE       = 4,
  parameter int unsigned IMG_ROWS   = 8,
  parameter int unsigned IMG_COLS   = 10
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             abort,
  input  logic                             tile_valid,
  output logic                             tile_ready,
  input  logic [DATA_WIDTH*TILE*TILE-1:0]  tile_data,
  output logic                             pix_valid,
  input  logic                             pix_ready,
  output logic [DATA_WIDTH-1:0]            pix_data,
  output logic [cnt_width(IMG_ROWS)-1:0]   pix_row,
  output logic [cnt_width(IMG_COLS)-1:0]   pix_col,
  output logic                             pix_last,
  output logic                             busy,
  output logic                             frame_done
);

  localparam int unsigned TILES_R = ceil_div(IMG_ROWS, TILE);
  localparam int unsigned TILES_C = ceil_div(IMG_COLS, TILE);

  if (TILE < 2) begin : g_bad_tile
    $error("winograd_tile_stitcher: TILE must be at least 2");
  end
  if (IMG_ROWS < 1) begin : g_bad_rows
    $error("winograd_tile_stitcher: IMG_ROWS must be at least 1");
  end
  if (IMG_COLS < 1) begin : g_bad_cols
    $error("winograd_tile_stitcher: IMG_COLS must be at least 1");
  end

  stitch_state_e                    state;
  logic [cnt_width(TILES_R)-1:0]    tr;
  logic [cnt_width(TILES_C)-1:0]    tc;
  logic                             tile_last;
  logic                             pix_end;
  logic                             tile_fire;
  logic                             pix_fire;
  logic [DATA_WIDTH-1:0]            img [IMG_ROWS][IMG_COLS];

  assign tile_fire = rst_n && !abort && (state == COLLECT) && tile_valid && tile_ready;
  assign pix_fire  = rst_n && !abort && (state == DRAIN) && pix_valid && pix_ready;

  winograd_raster_counter #(.ROWS(TILES_R), .COLS(TILES_C)) u_tile_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort),
    .inc   (tile_fire),
    .row   (tr),
    .col   (tc),
    .last  (tile_last)
  );

  winograd_raster_counter #(.ROWS(IMG_ROWS), .COLS(IMG_COLS)) u_pix_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort),
    .inc   (pix_fire),
    .row   (pix_row),
    .col   (pix_col),
    .last  (pix_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= COLLECT;
      tile_ready <= 1'b0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (abort) begin
      state      <= COLLECT;
      tile_ready <= 1'b1;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        COLLECT: begin
          if (tile_fire && tile_last) begin
            state      <= DRAIN;
            tile_ready <= 1'b0;
            pix_valid  <= 1'b1;
          end else begin
            tile_ready <= 1'b1;
          end
        end
        DRAIN: begin
          if (pix_fire && pix_end) begin
            state      <= COLLECT;
            tile_ready <= 1'b1;
            pix_valid  <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // Iterating over image cells (not tile elements) makes the overhang clip implicit.
  always_ff @(posedge clk) begin
    if (tile_fire) begin
      for (int unsigned r = 0; r < IMG_ROWS; r++) begin
        for (int unsigned c = 0; c < IMG_COLS; c++) begin
          if ((r / TILE) == 32'(tr) && (c / TILE) == 32'(tc)) begin
            img[r][c] <= tile_data[elem_lsb(r % TILE, c % TILE, TILE, DATA_WIDTH) +: DATA_WIDTH];
          end
        end
      end
    end
  end

  assign pix_data = img[pix_row][pix_col];
  assign pix_last = pix_valid && pix_end;
  assign busy     = (state != COLLECT) || (tr != '0) || (tc != '0);

endmodule
